// File: rtl/mult_sweep_checker.sv
// rtl/mult_sweep_checker.sv - exhaustive operand sweep checker for an external multiplier
// Walks every A/B pair, holds each for SETTLE cycles, then compares p_in to the exact product.
module mult_sweep_checker #(
   parameter int WIDTH  = 2,
   parameter int SETTLE = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic [WIDTH-1:0]     a_out,
   output logic [WIDTH-1:0]     b_out,
   input  logic [2*WIDTH-1:0]   p_in,
   output logic                 busy,
   output logic                 done,
   output logic                 pass,
   output logic [2*WIDTH:0]     err_count,
   output logic                 fail_valid,
   output logic [WIDTH-1:0]     first_fail_a,
   output logic [WIDTH-1:0]     first_fail_b,
   output logic [2*WIDTH-1:0]   first_fail_p
);

   localparam int PW = 2 * WIDTH;
   localparam logic [PW-1:0] IDX_LAST = '1;
   localparam logic [3:0]    SETTLE_LAST = 4'(SETTLE - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DRIVE = 2'd1,
      CHECK = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             r_state;
   state_t             w_next;
   logic [PW-1:0]      r_idx;
   logic [3:0]         r_settle_cnt;
   logic [PW:0]        r_err_count;
   logic               r_fail_valid;
   logic [WIDTH-1:0]   r_ff_a;
   logic [WIDTH-1:0]   r_ff_b;
   logic [PW-1:0]      r_ff_p;
   logic [PW-1:0]      w_golden;
   logic               w_mismatch;
   logic               w_settled;

   // Zero-extend before multiplying so the golden product keeps every bit.
   assign w_golden   = {{WIDTH{1'b0}}, a_out} * {{WIDTH{1'b0}}, b_out};
   assign w_mismatch = (p_in != w_golden);
   assign w_settled  = (r_settle_cnt == SETTLE_LAST);

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE, DONE: if (start) w_next = DRIVE;
         DRIVE:      if (w_settled) w_next = CHECK;
         CHECK:      w_next = (r_idx == IDX_LAST) ? DONE : DRIVE;
         default:    w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_idx        <= '0;
         r_settle_cnt <= '0;
         r_err_count  <= '0;
         r_fail_valid <= 1'b0;
         r_ff_a       <= '0;
         r_ff_b       <= '0;
         r_ff_p       <= '0;
      end else begin
         r_state <= w_next;
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_idx        <= '0;
                  r_settle_cnt <= '0;
                  r_err_count  <= '0;
                  r_fail_valid <= 1'b0;
                  r_ff_a       <= '0;
                  r_ff_b       <= '0;
                  r_ff_p       <= '0;
               end
            end
            DRIVE: begin
               r_settle_cnt <= w_settled ? 4'd0 : r_settle_cnt + 4'd1;
            end
            CHECK: begin
               if (w_mismatch) begin
                  r_err_count <= r_err_count + 1'b1;
                  if (!r_fail_valid) begin
                     r_fail_valid <= 1'b1;
                     r_ff_a       <= a_out;
                     r_ff_b       <= b_out;
                     r_ff_p       <= p_in;
                  end
               end
               // On the last pair idx stays put so DONE keeps showing the final operands.
               if (r_idx != IDX_LAST) r_idx <= r_idx + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign a_out        = r_idx[WIDTH-1:0];
   assign b_out        = r_idx[PW-1:WIDTH];
   assign busy         = (r_state == DRIVE) || (r_state == CHECK);
   assign done         = (r_state == DONE);
   assign pass         = done && (r_err_count == '0);
   assign err_count    = r_err_count;
   assign fail_valid   = r_fail_valid;
   assign first_fail_a = r_ff_a;
   assign first_fail_b = r_ff_b;
   assign first_fail_p = r_ff_p;

endmodule

// File: tb/tb_mult_sweep_checker.sv
// tb/tb_mult_sweep_checker.sv - scoreboard bench for mult_sweep_checker
// Two instances: SETTLE=1 against an ideal or stuck-bit multiplier, SETTLE=3 against a 3-cycle pipelined one.
module tb_mult_sweep_checker;

   typedef struct {
      int         cycles;
      logic       pass;
      logic [4:0] err;
      logic       fv;
      logic [1:0] ffa;
      logic [1:0] ffb;
      logic [3:0] ffp;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic       start3 = 1'b0;
   logic       fault = 1'b0;

   logic [1:0] a_out, b_out, ffa, ffb;
   logic [3:0] p_in, ffp, prod;
   logic       busy, done, pass, fail_valid;
   logic [4:0] err_count;

   logic [1:0] a3, b3, ffa3, ffb3;
   logic [3:0] p_in3, ffp3;
   logic       busy3, done3, pass3, fail_valid3;
   logic [4:0] err_count3;
   logic [3:0] d1 = '0, d2 = '0, d3 = '0;

   always #5 clk = ~clk;

   always_comb begin
      prod = {2'b00, a_out} * {2'b00, b_out};
      p_in = fault ? (prod & 4'b1110) : prod;
   end

   // Pipelined multiplier: product reflects the operands from three edges ago.
   always @(posedge clk) begin
      d1 <= {a3, b3};
      d2 <= d1;
      d3 <= d2;
   end
   assign p_in3 = {2'b00, d3[3:2]} * {2'b00, d3[1:0]};

   mult_sweep_checker #(.WIDTH(2), .SETTLE(1)) dut (
      .clk(clk), .rst(rst), .start(start),
      .a_out(a_out), .b_out(b_out), .p_in(p_in),
      .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .fail_valid(fail_valid),
      .first_fail_a(ffa), .first_fail_b(ffb), .first_fail_p(ffp)
   );

   mult_sweep_checker #(.WIDTH(2), .SETTLE(3)) dut3 (
      .clk(clk), .rst(rst), .start(start3),
      .a_out(a3), .b_out(b3), .p_in(p_in3),
      .busy(busy3), .done(done3), .pass(pass3),
      .err_count(err_count3), .fail_valid(fail_valid3),
      .first_fail_a(ffa3), .first_fail_b(ffb3), .first_fail_p(ffp3)
   );

   function automatic exp_t model(input bit stuck0, input int cyc);
      exp_t e;
      e = '{default: 0};
      e.cycles = cyc;
      for (int i = 0; i < 16; i++) begin
         int a = i % 4;
         int b = i / 4;
         int p = a * b;
         int obs = stuck0 ? (p & 14) : p;
         if (obs != p) begin
            if (!e.fv) begin
               e.fv  = 1'b1;
               e.ffa = 2'(a);
               e.ffb = 2'(b);
               e.ffp = 4'(obs);
            end
            e.err = e.err + 5'd1;
         end
      end
      e.pass = (e.err == 5'd0);
      return e;
   endfunction

   task automatic start_sweep(input bit use3, input bit stuck0, input bit push, input int cyc);
      fault = stuck0;
      if (push) sb.push_back(model(stuck0, cyc));
      if (use3) start3 = 1'b1;
      else start = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      start3 = 1'b0;
   endtask

   task automatic run_until_done(input bit use3, input int budget, input int restart_at,
                                 output int cycles, output bit busy_ok);
      cycles  = 0;
      busy_ok = 1'b1;
      while (!(use3 ? done3 : done) && cycles < budget) begin
         if (!(use3 ? busy3 : busy)) busy_ok = 1'b0;
         if (cycles == restart_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         cycles++;
      end
   endtask

   task automatic check_result(input bit use3, input int cycles, input bit busy_ok, input string tag);
      exp_t e;
      logic o_pass, o_fv, o_busy;
      logic [4:0] o_err;
      logic [1:0] o_ffa, o_ffb;
      logic [3:0] o_ffp;
      o_pass = use3 ? pass3 : pass;
      o_fv   = use3 ? fail_valid3 : fail_valid;
      o_busy = use3 ? busy3 : busy;
      o_err  = use3 ? err_count3 : err_count;
      o_ffa  = use3 ? ffa3 : ffa;
      o_ffb  = use3 ? ffb3 : ffb;
      o_ffp  = use3 ? ffp3 : ffp;
      checks++;
      if (sb.size() == 0) begin
         errors++;
         $display("FAIL %s scoreboard: queue empty", tag);
         return;
      end
      e = sb.pop_front();
      checks++;
      if (cycles !== e.cycles) begin
         errors++; $display("FAIL %s latency: got %0d want %0d", tag, cycles, e.cycles);
      end
      checks++;
      if (busy_ok !== 1'b1 || o_busy !== 1'b0) begin
         errors++; $display("FAIL %s busy: during=%0b after=%0b want 1/0", tag, busy_ok, o_busy);
      end
      checks++;
      if (o_pass !== e.pass) begin
         errors++; $display("FAIL %s pass: got %0b want %0b", tag, o_pass, e.pass);
      end
      checks++;
      if (o_err !== e.err) begin
         errors++; $display("FAIL %s err_count: got %0d want %0d", tag, o_err, e.err);
      end
      checks++;
      if (o_fv !== e.fv) begin
         errors++; $display("FAIL %s fail_valid: got %0b want %0b", tag, o_fv, e.fv);
      end
      checks++;
      if ({o_ffa, o_ffb, o_ffp} !== {e.ffa, e.ffb, e.ffp}) begin
         errors++;
         $display("FAIL %s first_fail a/b/p: got %0d/%0d/%0d want %0d/%0d/%0d",
                  tag, o_ffa, o_ffb, o_ffp, e.ffa, e.ffb, e.ffp);
      end
   endtask

   task automatic check_zero(input string tag);
      checks++;
      if ({a_out, b_out, err_count, fail_valid, ffa, ffb, ffp, busy, done, pass} !== '0) begin
         errors++;
         $display("FAIL %s outputs: got a=%0d b=%0d err=%0d fv=%0b ff=%0d/%0d/%0d busy=%0b done=%0b pass=%0b want all 0",
                  tag, a_out, b_out, err_count, fail_valid, ffa, ffb, ffp, busy, done, pass);
      end
   endtask

   task automatic test_reset();
      rst   = 1'b1;
      start = 1'b1;
      start3 = 1'b1;
      repeat (3) @(negedge clk);
      check_zero("reset");
      checks++;
      if ({a3, b3, err_count3, fail_valid3, ffa3, ffb3, ffp3, busy3, done3, pass3} !== '0) begin
         errors++; $display("FAIL reset dut3 outputs: got nonzero want all 0");
      end
      rst    = 1'b0;
      start  = 1'b0;
      start3 = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_ideal_sweep();
      int c; bit b;
      start_sweep(1'b0, 1'b0, 1'b1, 32);
      run_until_done(1'b0, 100, -1, c, b);
      check_result(1'b0, c, b, "ideal");
   endtask

   task automatic test_stuck_bit();
      int c; bit b;
      start_sweep(1'b0, 1'b1, 1'b1, 32);
      run_until_done(1'b0, 100, -1, c, b);
      check_result(1'b0, c, b, "stuck0");
   endtask

   task automatic test_restart_from_done();
      int c; bit b;
      start_sweep(1'b0, 1'b0, 1'b1, 32);
      checks++;
      if ({err_count, fail_valid, busy, done} !== {5'd0, 1'b0, 1'b1, 1'b0}) begin
         errors++;
         $display("FAIL restart clear: got err=%0d fv=%0b busy=%0b done=%0b want 0/0/1/0",
                  err_count, fail_valid, busy, done);
      end
      run_until_done(1'b0, 100, -1, c, b);
      check_result(1'b0, c, b, "restart");
   endtask

   task automatic test_start_ignored();
      int c; bit b;
      start_sweep(1'b0, 1'b0, 1'b1, 32);
      run_until_done(1'b0, 100, 10, c, b);
      check_result(1'b0, c, b, "start_ignored");
   endtask

   task automatic test_reset_mid_sweep();
      int c; bit b;
      start_sweep(1'b0, 1'b1, 1'b0, 0);
      repeat (17) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("mid_reset");
      rst = 1'b0;
      @(negedge clk);
      start_sweep(1'b0, 1'b0, 1'b1, 32);
      run_until_done(1'b0, 100, -1, c, b);
      check_result(1'b0, c, b, "after_reset");
   endtask

   task automatic test_settle3();
      int c; bit b;
      start_sweep(1'b1, 1'b0, 1'b1, 64);
      run_until_done(1'b1, 200, -1, c, b);
      check_result(1'b1, c, b, "settle3");
   endtask

   initial begin
      test_reset();
      test_ideal_sweep();
      test_stuck_bit();
      test_restart_from_done();
      test_start_ignored();
      test_reset_mid_sweep();
      test_settle3();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
